instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Upstream stage of the multicycle control unit. Owns the PC and the instruction register (IR). It fetches from instruction memory over a req/ack handshake and presents a stable 32-bit instruction to the control unit. It also applies the PC update (sequential and conditional branch) requested by the control signals PCWrite, PCWriteCond, PCSrc and BranchOp.

Parameters:
XLEN, 64, width of PC and ALU result paths
RESET_PC, 0, PC value after reset
TIMEOUT_CYC, 255, ack watchdog limit in cycles (used only with IMEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
PCWrite  in  1  unconditional PC load
PCWriteCond  in  1  conditional PC load (branch)
PCSrc  in  1  0: next PC = alu_result; 1: next PC = alu_out
BranchOp  in  1  0: BEQ (take if zero); 1: BNE (take if !zero)
zero  in  1  ALU zero flag
alu_result  in  XLEN  combinational ALU output (PC+4 path)
alu_out  in  XLEN  ALUOut register (branch target)
LoadIR  in  1  start fetch at current PC
imem_req  out  1  memory read request
imem_addr  out  XLEN  fetch address
imem_rdata  in  32  read data, valid when imem_ack=1
imem_ack  in  1  read complete
pc  out  XLEN  current PC
instruction  out  32  IR contents to control unit
instr_valid  out  1  IR holds completed fetch
fetch_stall  out  1  fetch in flight; control unit must hold state
fetch_err  out  1  watchdog fired (sticky; 0 when IMEM_TIMEOUT_EN is off)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-low.
- Reset (rst=0, async): pc=RESET_PC, instruction=0, instr_valid=0, imem_req=0, imem_addr=0, fetch_stall=0, fetch_err=0, FSM=F_IDLE.
- PC update (every edge, independent of the FSM):
  - taken = PCWriteCond & (zero ^ BranchOp).
  - If PCWrite|taken, then pc <= PCSrc ? alu_out : alu_result; otherwise pc holds.
  - PCWrite and PCWriteCond both high: treat as load.
- Fetch FSM:
  - F_IDLE: on LoadIR, imem_addr <= pc (pre-update value, captured the same edge the PC may update), imem_req <= 1, instr_valid <= 0, fetch_stall <= 1, go to F_WAIT.
  - F_WAIT: imem_req and imem_addr held stable until ack. When imem_ack=1: instruction <= imem_rdata, imem_req <= 0, fetch_stall <= 0, instr_valid <= 1, go to F_IDLE.
  - Minimum latency: LoadIR at edge N, ack in cycle N+1, IR valid after edge N+1 (2 cycles).
  - LoadIR while in F_WAIT: ignored (no queueing); the current fetch completes.
  - imem_ack while in F_IDLE: ignored; IR unchanged.
- IR and instr_valid hold their values between fetches. instr_valid clears only on a new fetch start or on reset.
- fetch_stall is registered; it is high exactly while the FSM is in F_WAIT.
- Reset mid-fetch: req drops asynchronously and the ack is lost; the first LoadIR after release refetches from RESET_PC.
- The PC is XLEN bits wide and wraps modulo 2^XLEN. Addresses are not checked for alignment.

Optional Feature:
IMEM_TIMEOUT_EN:
- Defined: a counter runs in F_WAIT. If the counter reaches TIMEOUT_CYC with no ack, fetch_err <= 1 (sticky until reset), instruction <= 32'h00000013 (NOP addi), instr_valid <= 1, imem_req <= 0, fetch_stall <= 0, and the FSM returns to F_IDLE.
- Undefined: no counter; F_WAIT waits indefinitely; fetch_err is tied to 0.

Decomposition:
- Shared package fetch_pkg: fetch FSM enum (F_IDLE, F_WAIT), NOP_INSTR constant, default RESET_PC.
- One sub-module: pc_reg (PC register plus next-PC/branch-taken logic), instantiated once.
- FSM, IR and watchdog live in the top module.

Test Plan:
- Reset release, LoadIR=1, ack next cycle with rdata=32'h00500093: imem_addr=0; IR=32'h00500093 and instr_valid=1 two edges after LoadIR; fetch_stall high for exactly 1 cycle.
- LoadIR with PCWrite=1, PCSrc=0, alu_result=4 on the same edge: imem_addr=0, pc=4 afterwards.
- BEQ: PCWriteCond=1, BranchOp=0, zero=1, PCSrc=1, alu_out=0x40 -> pc=0x40. Repeat with zero=0 -> pc unchanged.
- BNE: PCWriteCond=1, BranchOp=1, zero=0, alu_out=0x80 -> pc=0x80. With zero=1 -> pc unchanged.
- Ack delayed 5 cycles with a second LoadIR pulse mid-wait: single request, addr stable, fetch_stall high 5 cycles, IR takes the first rdata only.
- rst=0 asserted during F_WAIT: req drops without waiting for a clock edge, pc=RESET_PC. With IMEM_TIMEOUT_EN and TIMEOUT_CYC=8 and no ack: fetch_err=1, IR=32'h00000013.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_WAIT = 1'b1
    } fetchState_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register with sequential / conditional-branch next-PC selection.
import fetch_pkg::*;

module pc_reg #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            PCWriteCond,
    input  logic            PCSrc,
    input  logic            BranchOp,
    input  logic            zero,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] pc
);

    logic            taken;
    logic [XLEN-1:0] pcNext;

    // BranchOp selects BEQ (take on zero) or BNE (take on !zero).
    always_comb begin
        taken  = PCWriteCond & (zero ^ BranchOp);
        pcNext = pc;
        if (PCWrite | taken) begin
            pcNext = PCSrc ? alu_out : alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pcNext;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, fetches over a req/ack handshake to instruction memory.
// Optional ack watchdog enabled by defining IMEM_TIMEOUT_EN.
import fetch_pkg::*;

module instr_fetch_unit #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC),
    parameter int unsigned     TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            PCWriteCond,
    input  logic            PCSrc,
    input  logic            BranchOp,
    input  logic            zero,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] alu_out,
    input  logic            LoadIR,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instruction,
    output logic            instr_valid,
    output logic            fetch_stall,
    output logic            fetch_err
);

    if (TIMEOUT_CYC < 1) begin : gBadTimeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    fetchState_t     state, stateNext;
    logic            reqNext, validNext, stallNext;
    logic [XLEN-1:0] addrNext;
    logic [31:0]     irNext;

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) uPcReg (
        .clk         (clk),
        .rst         (rst),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSrc       (PCSrc),
        .BranchOp    (BranchOp),
        .zero        (zero),
        .alu_result  (alu_result),
        .alu_out     (alu_out),
        .pc          (pc)
    );

`ifdef IMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] waitCnt, waitCntNext;
    logic             errNext;
`endif

    // Next-state and next-register values; everything holds unless a transition fires.
    always_comb begin
        stateNext = state;
        reqNext   = imem_req;
        addrNext  = imem_addr;
        irNext    = instruction;
        validNext = instr_valid;
        stallNext = fetch_stall;
`ifdef IMEM_TIMEOUT_EN
        waitCntNext = waitCnt;
        errNext     = fetch_err;
`endif
        case (state)
            F_IDLE: begin
                if (LoadIR) begin
                    stateNext = F_WAIT;
                    reqNext   = 1'b1;
                    addrNext  = pc;
                    validNext = 1'b0;
                    stallNext = 1'b1;
`ifdef IMEM_TIMEOUT_EN
                    waitCntNext = '0;
`endif
                end
            end
            F_WAIT: begin
                if (imem_ack) begin
                    stateNext = F_IDLE;
                    reqNext   = 1'b0;
                    irNext    = imem_rdata;
                    validNext = 1'b1;
                    stallNext = 1'b0;
                end
`ifdef IMEM_TIMEOUT_EN
                else if (waitCnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Watchdog: retire a NOP so the control unit can make progress.
                    stateNext = F_IDLE;
                    reqNext   = 1'b0;
                    irNext    = NOP_INSTR;
                    validNext = 1'b1;
                    stallNext = 1'b0;
                    errNext   = 1'b1;
                end else begin
                    waitCntNext = waitCnt + CNT_W'(1);
                end
`endif
            end
            default: stateNext = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= F_IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            fetch_stall <= 1'b0;
        end else begin
            state       <= stateNext;
            imem_req    <= reqNext;
            imem_addr   <= addrNext;
            instruction <= irNext;
            instr_valid <= validNext;
            fetch_stall <= stallNext;
        end
    end

`ifdef IMEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt   <= '0;
            fetch_err <= 1'b0;
        end else begin
            waitCnt   <= waitCntNext;
            fetch_err <= errNext;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (IMEM_TIMEOUT_EN optional).
`timescale 1ns/1ps

module tb_instr_fetch_unit;

    localparam int unsigned XLEN = 64;

    logic            clk;
    logic            rst;
    logic            PCWrite, PCWriteCond, PCSrc, BranchOp, zero, LoadIR;
    logic [XLEN-1:0] alu_result, alu_out;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_ack;
    logic [XLEN-1:0] pc;
    logic [31:0]     instruction;
    logic            instr_valid, fetch_stall, fetch_err;

    int nChecks = 0;
    int nPass   = 0;

    instr_fetch_unit #(
        .XLEN        (XLEN),
        .RESET_PC    (64'h0),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSrc       (PCSrc),
        .BranchOp    (BranchOp),
        .zero        (zero),
        .alu_result  (alu_result),
        .alu_out     (alu_out),
        .LoadIR      (LoadIR),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .fetch_stall (fetch_stall),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle; inputs are then changed away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        PCWrite = 0; PCWriteCond = 0; PCSrc = 0; BranchOp = 0; zero = 0;
        LoadIR = 0; imem_ack = 0; imem_rdata = '0;
        alu_result = '0; alu_out = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clearInputs();
        repeat (2) step();
        nChecks++;
        if ({imem_req, fetch_stall, instr_valid, fetch_err} !== 4'b0000 ||
            pc !== 64'h0 || imem_addr !== 64'h0 || instruction !== 32'h0)
            $display("FAIL reset: req=%b stall=%b valid=%b err=%b pc=%h addr=%h ir=%h expected all zero",
                     imem_req, fetch_stall, instr_valid, fetch_err, pc, imem_addr, instruction);
        else nPass++;
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_first_fetch();
        int stallCycles = 0;
        LoadIR = 1;
        step();
        LoadIR = 0;
        if (fetch_stall) stallCycles++;
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0 || instr_valid !== 1'b0)
            $display("FAIL first_req: req=%b addr=%h valid=%b expected 1/0/0", imem_req, imem_addr, instr_valid);
        else nPass++;
        imem_ack = 1; imem_rdata = 32'h0050_0093;
        step();
        imem_ack = 0;
        if (fetch_stall) stallCycles++;
        nChecks++;
        if (instruction !== 32'h0050_0093 || instr_valid !== 1'b1 || imem_req !== 1'b0)
            $display("FAIL first_ir: ir=%h valid=%b req=%b expected 00500093/1/0", instruction, instr_valid, imem_req);
        else nPass++;
        nChecks++;
        if (stallCycles != 1) $display("FAIL first_stall: stall cycles=%0d expected 1", stallCycles);
        else nPass++;
    endtask

    task automatic test_ack_idle();
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 0;
        nChecks++;
        if (instruction !== 32'h0050_0093 || instr_valid !== 1'b1 || imem_req !== 1'b0)
            $display("FAIL ack_idle: ir=%h valid=%b req=%b expected 00500093/1/0", instruction, instr_valid, imem_req);
        else nPass++;
    endtask

    task automatic test_load_with_pc_write();
        LoadIR = 1; PCWrite = 1; PCSrc = 0; alu_result = 64'h4;
        step();
        LoadIR = 0; PCWrite = 0;
        nChecks++;
        if (imem_addr !== 64'h0 || pc !== 64'h4 || instr_valid !== 1'b0)
            $display("FAIL load_pcwrite: addr=%h pc=%h valid=%b expected 0/4/0", imem_addr, pc, instr_valid);
        else nPass++;
        imem_ack = 1; imem_rdata = 32'h0000_1111;
        step();
        imem_ack = 0;
        nChecks++;
        if (instruction !== 32'h0000_1111 || fetch_stall !== 1'b0)
            $display("FAIL load_pcwrite_ir: ir=%h stall=%b expected 00001111/0", instruction, fetch_stall);
        else nPass++;
    endtask

    task automatic test_branches();
        // BEQ taken, then not taken
        PCWriteCond = 1; BranchOp = 0; zero = 1; PCSrc = 1; alu_out = 64'h40;
        step();
        nChecks++;
        if (pc !== 64'h40) $display("FAIL beq_taken: pc=%h expected 40", pc); else nPass++;
        zero = 0; alu_out = 64'h99;
        step();
        nChecks++;
        if (pc !== 64'h40) $display("FAIL beq_not_taken: pc=%h expected 40", pc); else nPass++;
        // BNE taken, then not taken
        BranchOp = 1; zero = 0; alu_out = 64'h80;
        step();
        nChecks++;
        if (pc !== 64'h80) $display("FAIL bne_taken: pc=%h expected 80", pc); else nPass++;
        zero = 1; alu_out = 64'h77;
        step();
        nChecks++;
        if (pc !== 64'h80) $display("FAIL bne_not_taken: pc=%h expected 80", pc); else nPass++;
        // Both writes high with a not-taken branch still loads
        PCWrite = 1; BranchOp = 0; zero = 0; PCSrc = 0; alu_result = 64'h100; alu_out = 64'h555;
        step();
        nChecks++;
        if (pc !== 64'h100) $display("FAIL both_write: pc=%h expected 100", pc); else nPass++;
        clearInputs();
    endtask

    task automatic test_back_to_back();
        int stallCycles = 0;
        int badHold = 0;
        LoadIR = 1;
        step();
        LoadIR = 0;
        if (fetch_stall) stallCycles++;
        for (int i = 0; i < 4; i++) begin
            LoadIR  = (i == 1);
            PCWrite = (i == 2); alu_result = 64'h200;
            imem_rdata = 32'hBAD0_0000 | 32'(i);
            step();
            LoadIR = 0; PCWrite = 0;
            if (fetch_stall) stallCycles++;
            if (imem_req !== 1'b1 || imem_addr !== 64'h100) badHold++;
        end
        nChecks++;
        if (badHold != 0) $display("FAIL wait_hold: %0d cycles with req/addr changed, expected 0", badHold);
        else nPass++;
        imem_ack = 1; imem_rdata = 32'hAAAA_0001;
        step();
        if (fetch_stall) stallCycles++;
        imem_ack = 1; imem_rdata = 32'hBBBB_0002;
        nChecks++;
        if (stallCycles != 5) $display("FAIL wait_stall: stall cycles=%0d expected 5", stallCycles);
        else nPass++;
        step();
        imem_ack = 0;
        nChecks++;
        if (instruction !== 32'hAAAA_0001 || imem_req !== 1'b0 || fetch_stall !== 1'b0 || pc !== 64'h200)
            $display("FAIL wait_ir: ir=%h req=%b stall=%b pc=%h expected AAAA0001/0/0/200",
                     instruction, imem_req, fetch_stall, pc);
        else nPass++;
    endtask

    task automatic test_reset_mid_fetch();
        LoadIR = 1;
        step();
        LoadIR = 0;
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h200)
            $display("FAIL midrst_req: req=%b addr=%h expected 1/200", imem_req, imem_addr);
        else nPass++;
        #2 rst = 1'b0;
        #1;
        nChecks++;
        if (imem_req !== 1'b0 || pc !== 64'h0 || fetch_stall !== 1'b0)
            $display("FAIL midrst_async: req=%b pc=%h stall=%b expected 0/0/0", imem_req, pc, fetch_stall);
        else nPass++;
        imem_ack = 1; imem_rdata = 32'hCCCC_CCCC;
        @(negedge clk);
        rst = 1'b1;
        imem_ack = 0;
        step();
        LoadIR = 1;
        step();
        LoadIR = 0;
        nChecks++;
        if (imem_addr !== 64'h0 || imem_req !== 1'b1 || instruction !== 32'h0)
            $display("FAIL midrst_refetch: addr=%h req=%b ir=%h expected 0/1/0", imem_addr, imem_req, instruction);
        else nPass++;
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 0;
        nChecks++;
        if (instruction !== 32'h1234_5678 || instr_valid !== 1'b1)
            $display("FAIL midrst_ir: ir=%h valid=%b expected 12345678/1", instruction, instr_valid);
        else nPass++;
    endtask

    task automatic test_timeout();
        LoadIR = 1;
        step();
        LoadIR = 0;
        repeat (7) step();
`ifdef IMEM_TIMEOUT_EN
        nChecks++;
        if (fetch_stall !== 1'b1 || fetch_err !== 1'b0)
            $display("FAIL timeout_early: stall=%b err=%b expected 1/0", fetch_stall, fetch_err);
        else nPass++;
        step();
        nChecks++;
        if (fetch_err !== 1'b1 || instruction !== 32'h0000_0013 || instr_valid !== 1'b1 ||
            fetch_stall !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL timeout_fire: err=%b ir=%h valid=%b stall=%b req=%b expected 1/00000013/1/0/0",
                     fetch_err, instruction, instr_valid, fetch_stall, imem_req);
        else nPass++;
        repeat (3) step();
        nChecks++;
        if (fetch_err !== 1'b1) $display("FAIL timeout_sticky: err=%b expected 1", fetch_err);
        else nPass++;
`else
        repeat (20) step();
        nChecks++;
        if (fetch_stall !== 1'b1 || imem_req !== 1'b1 || fetch_err !== 1'b0)
            $display("FAIL no_watchdog: stall=%b req=%b err=%b expected 1/1/0", fetch_stall, imem_req, fetch_err);
        else nPass++;
`endif
        rst = 1'b0;
        #1;
        nChecks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL timeout_reset: err=%b req=%b expected 0/0", fetch_err, imem_req);
        else nPass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_ack_idle();
        test_load_with_pc_write();
        test_branches();
        test_back_to_back();
        test_reset_mid_fetch();
        test_timeout();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
